fetch_queue: RTL and testbench

- Parametrised instruction-fetch unit with a prefetch buffer. It replaces the single-register PC and next-PC adder in front of the synchronous instr_mem.
- Issues sequential fetches ahead of decode and buffers up to DEPTH {pc, instr} pairs.
- Presents the buffered pairs to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding the response already in flight.

---
 rtl/fetch_queue_if.sv | 41 ++++
 rtl/fetch_queue.sv | 149 ++++++++++++++
 tb/tb_fetch_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response, redirect input and decode handshake.
// master = fetch_queue side, slave = memory/decode environment side.
interface fetch_queue_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_en,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_en,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instr
  );

endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch unit with a DEPTH-entry prefetch buffer in front of a one-cycle instr_mem.
// Optional FETCH_STATS_EN adds saturating push/redirect counters (stat_fetched, stat_redirects).
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_INC   = 1
) (
  input  logic           clk,
  input  logic           clr,
  fetch_queue_if.master  bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]    stat_fetched,
  output logic [31:0]    stat_redirects
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  inflight_pc_q, inflight_pc_d;
  logic [XLEN-1:0]  buf_pc_q    [DEPTH];
  logic [XLEN-1:0]  buf_pc_d    [DEPTH];
  logic [XLEN-1:0]  buf_instr_q [DEPTH];
  logic [XLEN-1:0]  buf_instr_d [DEPTH];

  logic [OCC_W-1:0] occupancy_c;
  logic             issue_c;
  logic             push_c;
  logic             pop_c;
  logic             valid_c;

  // Credit check counts the in-flight response; same-cycle pops give no credit.
  assign occupancy_c = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign issue_c     = !clr && !bus.redirect_en && (occupancy_c < OCC_W'(DEPTH));
  assign push_c      = inflight_q && !bus.redirect_en;
  assign valid_c     = (count_q != '0);
  assign pop_c       = valid_c && bus.out_ready && !bus.redirect_en;

  // Next-state: redirect flushes everything and takes priority over issue, push and pop.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;

    if (bus.redirect_en) begin
      fetch_pc_d = bus.redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue_c) begin
        fetch_pc_d    = fetch_pc_q + XLEN'(PC_INC);
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end

      if (push_c) begin
        buf_pc_d[wr_ptr_q]    = inflight_pc_q;
        buf_instr_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end

      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      fetch_pc_q    <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]    <= '0;
        buf_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
    end
  end

  assign bus.imem_req  = issue_c;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = valid_c;
  assign bus.out_pc    = valid_c ? buf_pc_q[rd_ptr_q]    : '0;
  assign bus.out_instr = valid_c ? buf_instr_q[rd_ptr_q] : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_redirects_q, stat_redirects_d;

  // Saturating event counters.
  always_comb begin
    stat_fetched_d   = stat_fetched_q;
    stat_redirects_d = stat_redirects_q;
    if (push_c && (stat_fetched_q != '1)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (bus.redirect_en && (stat_redirects_q != '1)) begin
      stat_redirects_d = stat_redirects_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      stat_fetched_q   <= '0;
      stat_redirects_q <= '0;
    end else begin
      stat_fetched_q   <= stat_fetched_d;
      stat_redirects_q <= stat_redirects_d;
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_redirects = stat_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a main DUT (RESET_PC=0) and a wrap DUT (RESET_PC=FFFFFFFF).
module tb_fetch_queue;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  fetch_queue_if #(.XLEN(32)) bus ();
  fetch_queue_if #(.XLEN(32)) wbus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_redirects;
  logic [31:0] w_stat_fetched, w_stat_redirects;
`endif

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_INC(1)
  ) u_dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_redirects(stat_redirects)
`endif
  );

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFF), .PC_INC(1)
  ) u_wrap (
    .clk(clk),
    .clr(clr),
    .bus(wbus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(w_stat_fetched),
    .stat_redirects(w_stat_redirects)
`endif
  );

  // Synchronous instruction memory: data = addr + 0x100, one cycle after the request.
  always @(posedge clk) begin
    if (bus.imem_req)  bus.imem_rdata  <= bus.imem_addr + 32'h100;
    if (wbus.imem_req) wbus.imem_rdata <= wbus.imem_addr + 32'h100;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q [$];
  logic [31:0] wexp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted head is checked against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!clr && bus.out_valid && bus.out_ready && !bus.redirect_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h expected no output", bus.out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", bus.out_pc, e);
        chk("out_instr", bus.out_instr, e + 32'h100);
      end
    end
    if (!clr && wbus.out_valid && wbus.out_ready && !wbus.redirect_en) begin
      if (wexp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wrap_pop_unexpected: got pc %h expected no output", wbus.out_pc);
      end else begin
        e = wexp_q.pop_front();
        chk("wrap_out_pc", wbus.out_pc, e);
        chk("wrap_out_instr", wbus.out_instr, e + 32'h100);
      end
    end
  end

  // Hold out_ready until the scoreboard empties, then drop it; bounded.
  task automatic drain(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(posedge clk);
      i++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvalid;
    int nreq;
`ifdef FETCH_STATS_EN
    logic [31:0] redir_snap;
`endif
    clr              = 1'b1;
    bus.redirect_en  = 1'b0;
    bus.redirect_pc  = '0;
    bus.out_ready    = 1'b0;
    wbus.redirect_en = 1'b0;
    wbus.redirect_pc = '0;
    wbus.out_ready   = 1'b0;
    repeat (2) @(posedge clk);

    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);

    // Reset startup: stream pc 0..7 with no bubbles; wrap DUT streams FFFFFFFF, 0, 1.
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    wexp_q.push_back(32'hFFFF_FFFF);
    wexp_q.push_back(32'h0000_0000);
    wexp_q.push_back(32'h0000_0001);
    step();
    clr            = 1'b0;
    bus.out_ready  = 1'b1;
    wbus.out_ready = 1'b1;
    @(negedge clk);
    chk("c0_imem_req", 32'(bus.imem_req), 32'd1);
    chk("c0_imem_addr", bus.imem_addr, 32'd0);
    chk("c0_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("c1_out_valid", 32'(bus.out_valid), 32'd0);
    chk("c1_imem_addr", bus.imem_addr, 32'd1);
    nvalid = 0;
    for (int c = 2; c < 10; c++) begin
      step();
      if (c == 5) wbus.out_ready = 1'b0;
      @(negedge clk);
      if (bus.out_valid) nvalid++;
    end
    chk("stream_valid_cycles", 32'(nvalid), 32'd8);
    step();
    bus.out_ready = 1'b0;

    // Fill to full, then a one-cycle clr mid-operation.
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("full_stall_req", 32'(bus.imem_req), 32'd0);
    chk("full_head_valid", 32'(bus.out_valid), 32'd1);
    chk("full_head_pc", bus.out_pc, 32'd8);
    step();
    clr = 1'b1;
    @(negedge clk);
    chk("clr_forces_req_low", 32'(bus.imem_req), 32'd0);
    step();
    clr = 1'b0;

    // Backpressure from reset: exactly four requests at 0..3, head held at pc 0.
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      @(negedge clk);
      if (c == 0) begin
        chk("post_clr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_clr_out_pc", bus.out_pc, 32'd0);
        chk("post_clr_out_instr", bus.out_instr, 32'd0);
`ifdef FETCH_STATS_EN
        chk("post_clr_stat_fetched", stat_fetched, 32'd0);
        chk("post_clr_wrap_stat_fetched", w_stat_fetched, 32'd0);
`endif
      end
      if (bus.imem_req) begin
        chk("bp_req_addr", bus.imem_addr, 32'(nreq));
        nreq++;
      end
    end
    chk("bp_req_count", 32'(nreq), 32'd4);
    chk("bp_head_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_head_pc", bus.out_pc, 32'd0);
    chk("bp_head_instr", bus.out_instr, 32'h100);

    // Release backpressure: pcs 0..11 in order.
    step();
    for (int i = 0; i < 12; i++) exp_q.push_back(32'(i));
    bus.out_ready = 1'b1;
    drain("bp_drain_left", 64);

    // Redirect with 3 buffered + 1 in flight, out_ready=1 in the same cycle.
    @(negedge clk);
    chk("pre_redirect_valid", 32'(bus.out_valid), 32'd1);
`ifdef FETCH_STATS_EN
    redir_snap = stat_redirects;
`endif
    step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h40;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'h40 + 32'(i));
    step();
    bus.redirect_en = 1'b0;
    @(negedge clk);
    chk("redir_t1_valid", 32'(bus.out_valid), 32'd0);
    chk("redir_t1_req", 32'(bus.imem_req), 32'd1);
    chk("redir_t1_addr", bus.imem_addr, 32'h40);
`ifdef FETCH_STATS_EN
    chk("redir_stat_inc", stat_redirects, redir_snap + 32'd1);
`endif
    step();
    @(negedge clk);
    chk("redir_t2_valid", 32'(bus.out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("redir_t3_valid", 32'(bus.out_valid), 32'd1);
    chk("redir_t3_pc", bus.out_pc, 32'h40);
    drain("redir_drain_left", 32);

    // Back-to-back redirects: the last target wins.
    step();
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h80;
    step();
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect_en = 1'b0;
    bus.out_ready   = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i));
    @(negedge clk);
    chk("b2b_addr", bus.imem_addr, 32'h200);
    chk("b2b_valid", 32'(bus.out_valid), 32'd0);
    drain("b2b_drain_left", 32);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap_left", 32'(wexp_q.size()), 32'd0);
`ifdef FETCH_STATS_EN
    chk("wrap_stat_redirects", w_stat_redirects, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
